// File: rtl/fp_to_int.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_to_int : iterative IEEE-754 double -> int64/uint64 converter (fcvt.l[u].d)
// Revision  : 1.0
// ---------------------------------------------------------------------------
module fp_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic        is_signed,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        flag_nv,
  output logic        flag_nx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        s_r;
  logic        sgn_r;
  logic [2:0]  rm_r;
  logic        left_r;
  logic [5:0]  cnt;
  logic [63:0] w;
  logic        g;
  logic        st;

  logic [10:0]        exp_f;
  logic [52:0]        sig;
  logic signed [12:0] e_unb;
  logic signed [12:0] rdist;
  logic               is_nan;
  logic               is_special;
  logic               go_left;
  logic [5:0]         load_cnt;

  always_comb begin
    exp_f      = a[62:52];
    sig        = {(exp_f != 11'd0), a[51:0]};
    e_unb      = (exp_f == 11'd0) ? -13'sd1022 : ($signed({2'b00, exp_f}) - 13'sd1023);
    rdist      = 13'sd52 - e_unb;
    is_nan     = (exp_f == 11'h7FF) && (a[51:0] != 52'd0);
    is_special = (exp_f == 11'h7FF) || (e_unb >= 13'sd64);
    go_left    = (e_unb >= 13'sd52);
    load_cnt   = 6'd0;
    if (go_left) begin
      load_cnt = 6'(e_unb - 13'sd52);
    end else if (rdist > 13'sd54) begin
      load_cnt = 6'd54;
    end else begin
      load_cnt = 6'(rdist);
    end
  end

  // Saturated value for invalid conversions; NaN is passed in as positive.
  function automatic logic [63:0] ovf_val(input logic neg, input logic sgnd);
    if (sgnd) return neg ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    else      return neg ? 64'h0000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  logic        inc;
  logic [64:0] mg;
  logic        in_range;

  always_comb begin
    case (rm_r)
      3'd0:    inc = g & (st | w[0]);
      3'd2:    inc = s_r & (g | st);
      3'd3:    inc = ~s_r & (g | st);
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    mg = {1'b0, w} + {64'd0, inc};
    if (sgn_r) begin
      if (s_r) in_range = ~mg[64] & (~mg[63] | (mg[62:0] == 63'd0));
      else     in_range = (mg[64:63] == 2'b00);
    end else begin
      if (s_r) in_range = (mg == 65'd0);
      else     in_range = ~mg[64];
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_r     <= 1'b0;
      sgn_r   <= 1'b0;
      rm_r    <= 3'd0;
      left_r  <= 1'b0;
      cnt     <= 6'd0;
      w       <= 64'd0;
      g       <= 1'b0;
      st      <= 1'b0;
      result  <= 64'd0;
      flag_nv <= 1'b0;
      flag_nx <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_r   <= a[63];
            sgn_r <= is_signed;
            rm_r  <= rm;
            if (is_special) begin
              result  <= ovf_val(a[63] & ~is_nan, is_signed);
              flag_nv <= 1'b1;
              flag_nx <= 1'b0;
              state   <= DONE;
            end else begin
              w      <= {11'd0, sig};
              g      <= 1'b0;
              st     <= 1'b0;
              left_r <= go_left;
              cnt    <= load_cnt;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
            if (left_r) begin
              w <= w << 1;
            end else begin
              st <= st | g;
              g  <= w[0];
              w  <= w >> 1;
            end
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (in_range) begin
            result  <= s_r ? (64'd0 - mg[63:0]) : mg[63:0];
            flag_nx <= g | st;
            flag_nv <= 1'b0;
          end else begin
            result  <= ovf_val(s_r, sgn_r);
            flag_nx <= 1'b0;
            flag_nv <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_to_int : directed-vector bench for fp_to_int
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = 64'd0;
  logic        is_signed = 1'b0;
  logic [2:0]  rm = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        flag_nv;
  logic        flag_nx;

  int errors = 0;
  int checks = 0;

  fp_to_int dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .is_signed (is_signed),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_nv   (flag_nv),
    .flag_nx   (flag_nx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Accepts one operand, scrambles the inputs afterwards, and waits for the
  // result. lat counts clock edges after the accept edge; specials are
  // already valid in the cycle that follows the accept (lat 0).
  task automatic run_op(input string tag, input logic [63:0] av, input logic sg,
                        input logic [2:0] r, input logic [63:0] er,
                        input logic env, input logic enx, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    a         = av;
    is_signed = sg;
    rm        = r;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = ~av;
    is_signed = ~sg;
    rm        = 3'd4 - r;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " result"}, result, er);
    chk({tag, " nv"}, {63'd0, flag_nv}, {63'd0, env});
    chk({tag, " nx"}, {63'd0, flag_nx}, {63'd0, enx});
    chk({tag, " busy"}, {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " idle"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {result, 4'd0} >> 4 | 64'({in_ready, out_valid, flag_nv, flag_nx}), 64'h8);
    chk("reset result", result, 64'd0);
    rst_n = 1'b1;

    run_op("2.5 s RNE",   64'h4004_0000_0000_0000, 1'b1, 3'd0, 64'd2,                   1'b0, 1'b1, 53);
    run_op("3.5 s RNE",   64'h400C_0000_0000_0000, 1'b1, 3'd0, 64'd4,                   1'b0, 1'b1, 53);
    run_op("-2.5 s RDN",  64'hC004_0000_0000_0000, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 53);
    run_op("-2.5 s RTZ",  64'hC004_0000_0000_0000, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 53);
    run_op("2.5 s RMM",   64'h4004_0000_0000_0000, 1'b1, 3'd4, 64'd3,                   1'b0, 1'b1, 53);
    run_op("2.5 s RUP",   64'h4004_0000_0000_0000, 1'b1, 3'd3, 64'd3,                   1'b0, 1'b1, 53);
    run_op("2.5 s rm7",   64'h4004_0000_0000_0000, 1'b1, 3'd7, 64'd2,                   1'b0, 1'b1, 53);
    run_op("1.0 s RNE",   64'h3FF0_0000_0000_0000, 1'b1, 3'd0, 64'd1,                   1'b0, 1'b0, 54);
    run_op("2^52 u",      64'h4330_0000_0000_0000, 1'b0, 3'd0, 64'h0010_0000_0000_0000, 1'b0, 1'b0, 2);
    run_op("2^63 s",      64'h43E0_0000_0000_0000, 1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 13);
    run_op("2^63 u",      64'h43E0_0000_0000_0000, 1'b0, 3'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 13);
    run_op("-2^63 s",     64'hC3E0_0000_0000_0000, 1'b1, 3'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 13);
    run_op("NaN s",       64'h7FF8_0000_0000_0000, 1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("-NaN u",      64'hFFF8_0000_0000_0001, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("-inf u",      64'hFFF0_0000_0000_0000, 1'b0, 3'd0, 64'd0,                   1'b1, 1'b0, 0);
    run_op("-inf s",      64'hFFF0_0000_0000_0000, 1'b1, 3'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 0);
    run_op("1e300 u",     64'h7E37_E43C_8800_759C, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("-0.3 u RTZ",  64'hBFD3_3333_3333_3333, 1'b0, 3'd1, 64'd0,                   1'b0, 1'b1, 56);
    run_op("-1.0 u",      64'hBFF0_0000_0000_0000, 1'b0, 3'd1, 64'd0,                   1'b1, 1'b0, 54);
    run_op("-0.0 u",      64'h8000_0000_0000_0000, 1'b0, 3'd0, 64'd0,                   1'b0, 1'b0, 56);
    run_op("subn s RUP",  64'h0000_0000_0000_0001, 1'b1, 3'd3, 64'd1,                   1'b0, 1'b1, 56);
    run_op("subn s RNE",  64'h0000_0000_0000_0001, 1'b1, 3'd0, 64'd0,                   1'b0, 1'b1, 56);
    run_op("-subn u RDN", 64'h8000_0000_0000_0001, 1'b0, 3'd2, 64'd0,                   1'b1, 1'b0, 56);

    // Back-pressure: result must hold while out_ready stays low.
    @(negedge clk);
    a = 64'h400C_0000_0000_0000; is_signed = 1'b1; rm = 3'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold latency", 64'(lat), 64'd53);
    for (int i = 0; i < 5; i++) begin
      chk("hold result", result, 64'd4);
      chk("hold flags", {62'd0, flag_nv, flag_nx}, 64'd1);
      chk("hold ready", {62'd0, out_valid, in_ready}, 64'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    chk("hold ready w/ out_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold release", {62'd0, out_valid, in_ready}, 64'd1);

    // Reset in the middle of a long right shift.
    @(negedge clk);
    a = 64'h8000_0000_0000_0000; is_signed = 1'b0; rm = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset busy", {62'd0, out_valid, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid-reset state", {62'd0, out_valid, in_ready}, 64'd1);
    chk("mid-reset result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("post-reset state", {62'd0, out_valid, in_ready}, 64'd1);
    chk("post-reset result", result, 64'd0);

    run_op("after reset 3.5 RTZ", 64'h400C_0000_0000_0000, 1'b0, 3'd1, 64'd3, 1'b0, 1'b1, 53);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
